// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the RAW hazard scoreboard; these match the codes
// emitted by instruction decode.
package hazard_scoreboard_pkg;

    // Operand "read at stage" codes (11 is treated as none)
    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_EX   = 2'b01;
    localparam logic [1:0] RD_MEM  = 2'b10;

    // Result-forwardable-after-stage codes
    localparam logic [1:0] AV_EX  = 2'b01;
    localparam logic [1:0] AV_MEM = 2'b10;

    function automatic logic [1:0] need_code(input logic [1:0] rd);
        return (rd == 2'b11) ? RD_NONE : rd;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-operand lookup: finds the youngest in-flight writer of a source register
// and decides whether its result is still too late to forward.
module hazard_scoreboard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned KW     = 2
) (
    input  logic [DEPTH-1:0]        slot_valid,
    input  logic [DEPTH*REG_AW-1:0] slot_dst,
    input  logic [DEPTH*2-1:0]      slot_avail,
    input  logic [REG_AW-1:0]       src_addr,
    input  logic [1:0]              src_need,
    output logic                    hit,
    output logic [KW-1:0]           k,
    output logic                    hazard
);

    logic [1:0] need;
    logic [1:0] av;

    always_comb begin
        need = need_code(src_need);
        hit  = 1'b0;
        k    = '0;
        av   = '0;
        // Walk oldest to youngest so the youngest match is the one left standing
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_dst[i*REG_AW +: REG_AW] == src_addr) &&
                (src_addr != '0) && (need != RD_NONE)) begin
                hit = 1'b1;
                k   = KW'(i + 1);
                av  = slot_avail[2*i +: 2];
            end
        end
        hazard = hit && ((32'(need) + 32'(k)) <= 32'(av));
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit beside ID: shift scoreboard of in-flight writers, stall
// request, per-operand forwarding selects and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [1:0]        read_rs,
    input  logic [1:0]        read_rt,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [1:0]        wr_avail,
    output logic              stall,
    output logic [FW-1:0]     fwd_rs,
    output logic [FW-1:0]     fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Bit/field i holds slot i+1 (slot 1 = EX)
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH*REG_AW-1:0] dst_q, dst_d;
    logic [DEPTH*2-1:0]      avail_q, avail_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic hit_rs, hit_rt;
    logic hazard_rs, hazard_rt;
    logic load;

    hazard_scoreboard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .KW     (FW)
    ) u_match_rs (
        .slot_valid (valid_q),
        .slot_dst   (dst_q),
        .slot_avail (avail_q),
        .src_addr   (rs_addr),
        .src_need   (read_rs),
        .hit        (hit_rs),
        .k          (fwd_rs),
        .hazard     (hazard_rs)
    );

    hazard_scoreboard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .KW     (FW)
    ) u_match_rt (
        .slot_valid (valid_q),
        .slot_dst   (dst_q),
        .slot_avail (avail_q),
        .src_addr   (rt_addr),
        .src_need   (read_rt),
        .hit        (hit_rt),
        .k          (fwd_rt),
        .hazard     (hazard_rt)
    );

    // Flush masks the stall; a flushed instruction never enters slot 1
    assign stall     = id_valid & ~flush & (hazard_rs | hazard_rt);
    assign load      = id_valid & ~stall & ~flush;
    assign stall_cnt = cnt_q;

    always_comb begin
        valid_d = '0;
        dst_d   = '0;
        avail_d = '0;
        valid_d[0]        = load & wr_en & (wr_addr != '0);
        dst_d[REG_AW-1:0] = wr_addr;
        avail_d[1:0]      = wr_avail;
        for (int i = 1; i < int'(DEPTH); i++) begin
            valid_d[i]                  = valid_q[i-1];
            dst_d[i*REG_AW +: REG_AW]   = dst_q[(i-1)*REG_AW +: REG_AW];
            avail_d[2*i +: 2]           = avail_q[2*(i-1) +: 2];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dst_q   <= '0;
            avail_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            avail_q <= avail_d;
            cnt_q   <= cnt_d;
        end
    end

    logic unused_hits;
    assign unused_hits = hit_rs ^ hit_rt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed instruction stream pushes hand-computed expected
// outputs; a monitor pops and compares once per cycle on the falling edge.
module tb_hazard_scoreboard;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FW     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid, flush, wr_en;
    logic [REG_AW-1:0] rs_addr, rt_addr, wr_addr;
    logic [1:0]        read_rs, read_rt, wr_avail;
    logic              stall;
    logic [FW-1:0]     fwd_rs, fwd_rt;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  fwd_rs;
        logic [1:0]  fwd_rt;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .flush     (flush),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .read_rs   (read_rs),
        .read_rt   (read_rt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_avail  (wr_avail),
        .stall     (stall),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || fwd_rs !== e.fwd_rs || fwd_rt !== e.fwd_rt ||
                stall_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL %s: got stall=%0d fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0d fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         e.name, stall, fwd_rs, fwd_rt, stall_cnt,
                         e.stall, e.fwd_rs, e.fwd_rt, e.cnt);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue the expectation
    task automatic step(input string nm, input logic rst, input logic v, input logic fl,
                        input int rs, input logic [1:0] rrs, input int rt,
                        input logic [1:0] rrt, input logic we, input int wa,
                        input logic [1:0] wav, input logic e_st, input int e_rs,
                        input int e_rt, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rst;
        id_valid = v;
        flush    = fl;
        rs_addr  = REG_AW'(rs);
        read_rs  = rrs;
        rt_addr  = REG_AW'(rt);
        read_rt  = rrt;
        wr_en    = we;
        wr_addr  = REG_AW'(wa);
        wr_avail = wav;
        e.name   = nm;
        e.stall  = e_st;
        e.fwd_rs = 2'(e_rs);
        e.fwd_rt = 2'(e_rt);
        e.cnt    = 4'(e_cnt);
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; wr_en = 1'b0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0;
        read_rs = 2'b00; read_rt = 2'b00; wr_avail = 2'b00;

        //    name           rst v fl  rs rrs    rt rrt    we wa wav    st rs rt cnt
        step("reset",        0, 0, 0,  0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        step("load_r2",      1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 2, 2'b10, 0, 0, 0, 0);
        step("use_stall",    1, 1, 0,  2, 2'b01, 0, 2'b00, 1, 4, 2'b01, 1, 1, 0, 0);
        step("use_fwd2",     1, 1, 0,  2, 2'b01, 0, 2'b00, 1, 4, 2'b01, 0, 2, 0, 1);
        step("load_r2b",     1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 2, 2'b10, 0, 0, 0, 1);
        step("sw_data",      1, 1, 0,  0, 2'b00, 2, 2'b10, 0, 0, 2'b00, 0, 0, 1, 1);
        step("add_r3_fwd3",  1, 1, 0,  4, 2'b01, 0, 2'b00, 1, 3, 2'b01, 0, 3, 0, 1);
        step("sub_r3_r3",    1, 1, 0,  3, 2'b01, 3, 2'b01, 1, 6, 2'b01, 0, 1, 1, 1);
        step("nop",          1, 1, 0,  0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1);
        step("r3_slot3",     1, 1, 0,  3, 2'b01, 3, 2'b11, 0, 0, 2'b00, 0, 3, 0, 1);
        step("write_r0",     1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 0, 2'b10, 0, 0, 0, 1);
        step("read_r0",      1, 1, 0,  0, 2'b01, 0, 2'b10, 1, 5, 2'b01, 0, 0, 0, 1);
        step("write_r5",     1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 5, 2'b01, 0, 0, 0, 1);
        step("r5_youngest",  1, 1, 0,  5, 2'b01, 5, 2'b10, 0, 0, 2'b00, 0, 1, 1, 1);
        step("load_r7",      1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 7, 2'b10, 0, 0, 0, 1);
        step("flush_use",    1, 1, 1,  7, 2'b01, 0, 2'b00, 1, 8, 2'b01, 0, 1, 0, 1);
        step("after_flush",  1, 1, 0,  8, 2'b01, 7, 2'b01, 0, 0, 2'b00, 0, 0, 2, 1);
        step("load_r9",      1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 9, 2'b10, 0, 0, 0, 1);
        step("use_r9_stall", 1, 1, 0,  9, 2'b01, 0, 2'b00, 0, 0, 2'b00, 1, 1, 0, 1);
        step("async_reset",  0, 1, 0,  9, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        step("post_reset",   1, 1, 0,  9, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);

        // 2^CNT_W+5 load-use stalls; counter must stop at all ones
        cnt = 0;
        for (int i = 0; i < 21; i++) begin
            step("sat_load",  1, 1, 0,  0, 2'b00, 0, 2'b00, 1, 10, 2'b10, 0, 0, 0, cnt);
            step("sat_use",   1, 1, 0, 10, 2'b01, 0, 2'b00, 0, 0,  2'b00, 1, 1, 0, cnt);
            cnt = (cnt == 15) ? 15 : cnt + 1;
        end
        step("saturated",    1, 1, 0,  0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 15);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
